regfile_16x20: RTL and testbench

REGFILE_16X20 -- requirements
Module: regfile_16x20

---
 rtl/regfile_16x20_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 31 +++
 rtl/regfile_16x20.sv | 72 +++++++
 tb/tb_regfile_16x20.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_16x20_pkg.sv
// Shared defaults and address type for the 16x20 register file with issue scoreboard.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_16x20_pkg;

  localparam int WIDTH_DEF = 20;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage : regfile_16x20_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue (mark), cleared on write-back.
module regfile_scoreboard
  import regfile_16x20_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             mark_en,
  input  logic [AW-1:0]    mark_addr,
  output logic [DEPTH-1:0] pending,
  output logic             busy_any
);

  // NOTE: non-blocking assignments to the same bit resolve to the last one
  // written, so placing the mark after the clear makes the new producer win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_en)   pending[wr_addr]   <= 1'b0;
      if (mark_en) pending[mark_addr] <= 1'b1;
    end
  end

  assign busy_any = |pending;

endmodule : regfile_scoreboard

// File: rtl/regfile_16x20.sv
// 16x20 register file with two combinational read ports and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) onto the read ports.
module regfile_16x20
  import regfile_16x20_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mark_en,
  input  logic [AW-1:0]    mark_addr,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  output logic             busy_any
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  // NOTE: the array is reset deliberately -- reads must return 0 after reset,
  // which rules out mapping it onto a RAM macro without reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .pending   (pending),
    .busy_any  (busy_any)
  );

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
    ra_busy = pending[ra_addr];
    rb_busy = pending[rb_addr];
`ifdef REGFILE_BYPASS_EN
    // A write that is being reset away has nothing to forward.
    if (wr_en && !rst && (wr_addr == ra_addr)) begin
      ra_data = wr_data;
      ra_busy = 1'b0;
    end
    if (wr_en && !rst && (wr_addr == rb_addr)) begin
      rb_data = wr_data;
      rb_busy = 1'b0;
    end
`endif
  end

endmodule : regfile_16x20

// File: tb/tb_regfile_16x20.sv
// Self-checking bench for regfile_16x20: directed scenarios plus random traffic against an array model.
// Compile with REGFILE_BYPASS_EN defined to check the bypass build.
module tb_regfile_16x20;
  import regfile_16x20_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en, mark_en;
  reg_addr_t       wr_addr, mark_addr, ra_addr, rb_addr;
  logic [19:0]     wr_data;
  logic [19:0]     ra_data, rb_data;
  logic            ra_busy, rb_busy, busy_any;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays of stored values and pending flags.
  logic [19:0] m_val  [16];
  bit          m_pend [16];

  regfile_16x20 dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .ra_busy   (ra_busy),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .rb_busy   (rb_busy),
    .busy_any  (busy_any)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_val[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  // Expected outputs for the current inputs, from the model's stored state.
  function automatic void model_out(input reg_addr_t a, output logic [19:0] d, output logic b);
    d = m_val[a];
    b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !rst && wr_addr == a) begin
      d = wr_data;
      b = 1'b0;
    end
`endif
    if (rst) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  function automatic logic model_any();
    logic any = 1'b0;
    if (!rst) for (int i = 0; i < 16; i++) any |= m_pend[i];
    return any;
  endfunction

  // One rising edge: apply the model's update rules, then return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (wr_en) begin
        m_val[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (mark_en) m_pend[mark_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; mark_en = 1'b0;
    wr_addr = '0; mark_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    ra_addr = 4'd0; rb_addr = 4'd5;
    model_clear();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 20'h11111; mark_en = 1'b1; mark_addr = 4'd5;
    cycle();
    #1;
    checks++; if (ra_data !== 20'h0 || rb_data !== 20'h0) begin errors++;
      $display("FAIL reset_data got a=%h b=%h exp 0", ra_data, rb_data); end
    checks++; if ({ra_busy, rb_busy, busy_any} !== 3'b000) begin errors++;
      $display("FAIL reset_busy got %b exp 000", {ra_busy, rb_busy, busy_any}); end
    idle();
    rst = 1'b0;
    #1;
    checks++; if (rb_data !== 20'h0 || busy_any !== 1'b0) begin errors++;
      $display("FAIL after_reset got b=%h any=%b exp 0/0", rb_data, busy_any); end
    cycle();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 20'h12345; ra_addr = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ra_data !== 20'h12345) begin errors++;
      $display("FAIL bypass_write got %h exp 12345", ra_data); end
`else
    checks++; if (ra_data !== 20'h0) begin errors++;
      $display("FAIL write_not_early got %h exp 00000", ra_data); end
`endif
    cycle();
    idle();
    #1;
    checks++; if (ra_data !== 20'h12345) begin errors++;
      $display("FAIL write_read got %h exp 12345", ra_data); end
  endtask

  task automatic test_scoreboard();
    mark_en = 1'b1; mark_addr = 4'd7; ra_addr = 4'd7;
    cycle();
    idle();
    #1;
    checks++; if (ra_busy !== 1'b1 || busy_any !== 1'b1) begin errors++;
      $display("FAIL mark got busy=%b any=%b exp 1/1", ra_busy, busy_any); end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 20'h0BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ra_busy !== 1'b0) begin errors++;
      $display("FAIL bypass_busy got %b exp 0", ra_busy); end
`else
    checks++; if (ra_busy !== 1'b1) begin errors++;
      $display("FAIL busy_until_edge got %b exp 1", ra_busy); end
`endif
    cycle();
    idle();
    #1;
    checks++; if (ra_busy !== 1'b0 || busy_any !== 1'b0 || ra_data !== 20'h0BEEF) begin errors++;
      $display("FAIL writeback got busy=%b any=%b d=%h exp 0/0/0beef", ra_busy, busy_any, ra_data); end
  endtask

  task automatic test_simultaneous();
    mark_en = 1'b1; mark_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 20'hFFFFF;
    ra_addr = 4'd2; rb_addr = 4'd2;
`ifdef REGFILE_BYPASS_EN
    #1;
    checks++; if (ra_busy !== 1'b0 || rb_busy !== 1'b0 || rb_data !== 20'hFFFFF) begin errors++;
      $display("FAIL bypass_same got busy=%b/%b d=%h exp 0/0/fffff", ra_busy, rb_busy, rb_data); end
`endif
    cycle();
    idle();
    #1;
    checks++; if (ra_busy !== 1'b1 || rb_busy !== 1'b1 || ra_data !== 20'hFFFFF || rb_data !== 20'hFFFFF) begin errors++;
      $display("FAIL same_addr got busy=%b/%b d=%h/%h exp 1/1/fffff", ra_busy, rb_busy, ra_data, rb_data); end
    // Different addresses: mark R9 and retire R2 together.
    mark_en = 1'b1; mark_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 20'h00042;
    ra_addr = 4'd9;
    cycle();
    idle();
    #1;
    checks++; if (ra_busy !== 1'b1 || rb_busy !== 1'b0 || rb_data !== 20'h00042) begin errors++;
      $display("FAIL diff_addr got busy=%b/%b d=%h exp 1/0/00042", ra_busy, rb_busy, rb_data); end
    // Mark an already-pending register, then write R9 and a non-pending R4.
    mark_en = 1'b1; mark_addr = 4'd9;
    cycle();
    idle();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 20'h00009;
    cycle();
    wr_addr = 4'd4; wr_data = 20'h00004; rb_addr = 4'd4;
    cycle();
    idle();
    #1;
    checks++; if (ra_busy !== 1'b0 || rb_busy !== 1'b0 || busy_any !== 1'b0 || ra_data !== 20'h00009 || rb_data !== 20'h00004) begin errors++;
      $display("FAIL remark_retire got busy=%b/%b any=%b d=%h/%h exp 0/0/0/00009/00004", ra_busy, rb_busy, busy_any, ra_data, rb_data); end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 20'(i * 20'h01111);
      cycle();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(15 - i);
      #1;
      checks++; if (ra_data !== 20'(i * 20'h01111) || rb_data !== 20'((15 - i) * 20'h01111)) begin errors++;
        $display("FAIL sweep[%0d] got %h/%h exp %h/%h", i, ra_data, rb_data, 20'(i * 20'h01111), 20'((15 - i) * 20'h01111)); end
      rb_addr = 4'(i);
      #1;
      checks++; if (rb_data !== ra_data || rb_busy !== ra_busy) begin errors++;
        $display("FAIL same_port[%0d] got %h/%b exp %h/%b", i, rb_data, rb_busy, ra_data, ra_busy); end
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 20'hABCDE;
    mark_en = 1'b1; mark_addr = 4'd11;
    cycle();
    idle();
    ra_addr = 4'd5; rb_addr = 4'd11;
    #1;
    checks++; if (ra_data !== 20'hABCDE || busy_any !== 1'b1) begin errors++;
      $display("FAIL pre_reset got %h any=%b exp abcde/1", ra_data, busy_any); end
    // Asynchronous assertion between edges, with traffic that must be discarded.
    #1 rst = 1'b1;
    model_clear();
    wr_en = 1'b1; wr_data = 20'h13579; mark_en = 1'b1; mark_addr = 4'd5;
    #1;
    checks++; if (ra_data !== 20'h0 || busy_any !== 1'b0 || rb_busy !== 1'b0) begin errors++;
      $display("FAIL mid_reset got %h any=%b busy=%b exp 0/0/0", ra_data, busy_any, rb_busy); end
    cycle();
    idle();
    rst = 1'b0;
    #1;
    checks++; if (ra_data !== 20'h0 || busy_any !== 1'b0 || ra_busy !== 1'b0) begin errors++;
      $display("FAIL post_reset got %h any=%b busy=%b exp 0/0/0", ra_data, busy_any, ra_busy); end
    cycle();
  endtask

  task automatic test_random();
    logic [19:0] ea, eb;
    logic        eab, ebb;
    for (int c = 0; c < 1000; c++) begin
      wr_en     = ($urandom_range(0, 99) < 45);
      mark_en   = ($urandom_range(0, 99) < 35);
      wr_addr   = 4'($urandom_range(0, 15));
      mark_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      wr_data   = 20'($urandom());
      ra_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rb_addr   = ($urandom_range(0, 3) == 0) ? ra_addr : 4'($urandom_range(0, 15));
      #1;
      model_out(ra_addr, ea, eab);
      model_out(rb_addr, eb, ebb);
      checks++; if (ra_data !== ea || ra_busy !== eab) begin errors++;
        $display("FAIL rand_a cyc=%0d got %h/%b exp %h/%b", c, ra_data, ra_busy, ea, eab); end
      checks++; if (rb_data !== eb || rb_busy !== ebb) begin errors++;
        $display("FAIL rand_b cyc=%0d got %h/%b exp %h/%b", c, rb_data, rb_busy, eb, ebb); end
      checks++; if (busy_any !== model_any()) begin errors++;
        $display("FAIL rand_any cyc=%0d got %b exp %b", c, busy_any, model_any()); end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_16x20
